// File: rtl/mem_stage.sv
// Memory-access stage: resolves the branch, performs latency-modelled loads and stores
// against a word-addressed data RAM, and registers results into the MEM/WB boundary.
module mem_stage #(
  parameter int DEPTH   = 128,
  parameter int MEM_LAT = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        WB_RegWrite_i,
  input  logic        WB_MemtoReg_i,
  input  logic        M_branch_i,
  input  logic        M_MemRead_i,
  input  logic        M_MemWrite_i,
  input  logic [31:0] Adder2_i,
  input  logic        zero_i,
  input  logic [31:0] ALU_result_i,
  input  logic [31:0] Write_data_i,
  input  logic [4:0]  MUX2_i,
  output logic        PCSrc_o,
  output logic [31:0] branch_target_o,
  output logic        stall_o,
  output logic        WB_RegWrite_o,
  output logic        WB_MemtoReg_o,
  output logic [31:0] Read_data_o,
  output logic [31:0] ALU_result_o,
  output logic [4:0]  MUX2_o,
  output logic        misalign_o
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   mem [DEPTH];
  logic          access, aligned, is_read, commit, bubble, stall, mem_we;
  logic [AW-1:0] idx;
  logic          rw_q, rw_d, m2r_q, m2r_d, mis_q, mis_d;
  logic [31:0]   rdata_q, rdata_d, alu_q, alu_d;
  logic [4:0]    mux_q, mux_d;
  logic          unused_addr_hi;

  assign access  = M_MemRead_i | M_MemWrite_i;
  assign aligned = (ALU_result_i[1:0] == 2'b00);
  assign is_read = M_MemRead_i & ~M_MemWrite_i;
  assign idx     = ALU_result_i[AW+1:2];
  // Upper address bits are dropped so the address space wraps modulo DEPTH words.
  assign unused_addr_hi = ^ALU_result_i[31:AW+2];

  assign PCSrc_o         = M_branch_i & zero_i;
  assign branch_target_o = Adder2_i;
  assign stall_o         = stall & ~rst_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    commit  = 1'b0;
    bubble  = 1'b0;
    case (state_q)
      IDLE: begin
        if (access && aligned) begin
          if (MEM_LAT == 1) begin
            commit = 1'b1;
          end else begin
            stall   = 1'b1;
            bubble  = 1'b1;
            cnt_d   = 4'(MEM_LAT - 1);
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q > 4'd1) begin
          stall  = 1'b1;
          bubble = 1'b1;
          cnt_d  = cnt_q - 4'd1;
        end else begin
          commit  = 1'b1;
          cnt_d   = 4'd0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rw_d    = WB_RegWrite_i;
    m2r_d   = WB_MemtoReg_i;
    alu_d   = ALU_result_i;
    mux_d   = MUX2_i;
    rdata_d = 32'd0;
    mis_d   = (state_q == IDLE) && access && !aligned;
    if (bubble) begin
      rw_d  = 1'b0;
      m2r_d = 1'b0;
      alu_d = 32'd0;
      mux_d = 5'd0;
    end else if (commit && is_read) begin
      rdata_d = mem[idx];
    end
  end

  // A write that would coincide with reset is dropped, so an aborted access never lands.
  assign mem_we = commit & M_MemWrite_i & ~rst_i;

  always_ff @(posedge clk_i) begin
    if (mem_we) mem[idx] <= Write_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rw_q    <= 1'b0;
      m2r_q   <= 1'b0;
      rdata_q <= 32'd0;
      alu_q   <= 32'd0;
      mux_q   <= 5'd0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      m2r_q   <= m2r_d;
      rdata_q <= rdata_d;
      alu_q   <= alu_d;
      mux_q   <= mux_d;
      mis_q   <= mis_d;
    end
  end

  assign WB_RegWrite_o = rw_q;
  assign WB_MemtoReg_o = m2r_q;
  assign Read_data_o   = rdata_q;
  assign ALU_result_o  = alu_q;
  assign MUX2_o        = mux_q;
  assign misalign_o    = mis_q;
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: three instances with MEM_LAT 1, 2 and 3, one active at a time.
module tb_mem_stage;
  typedef struct packed {
    logic rw, m2r, br, mr, mw;
    logic [31:0] add2;
    logic zero;
    logic [31:0] alu, wd;
    logic [4:0] mux;
  } in_t;

  typedef struct packed {
    logic stall, pcs;
    logic [31:0] bt;
    logic rw, m2r;
    logic [31:0] rd, alu;
    logic [4:0] mux;
    logic mis;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] sel = 2'd1;
  in_t din = '0;
  in_t d [3];
  always_comb for (int k = 0; k < 3; k++) d[k] = (sel == 2'(k)) ? din : '0;

  logic [2:0]  stall_w, pcs_w, rw_w, m2r_w, mis_w;
  logic [31:0] bt_w [3];
  logic [31:0] rd_w [3];
  logic [31:0] alu_w [3];
  logic [4:0]  mux_w [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_stage #(.DEPTH(128), .MEM_LAT(g + 1)) u_dut (
      .clk_i(clk), .rst_i(rst),
      .WB_RegWrite_i(d[g].rw), .WB_MemtoReg_i(d[g].m2r),
      .M_branch_i(d[g].br), .M_MemRead_i(d[g].mr), .M_MemWrite_i(d[g].mw),
      .Adder2_i(d[g].add2), .zero_i(d[g].zero), .ALU_result_i(d[g].alu),
      .Write_data_i(d[g].wd), .MUX2_i(d[g].mux),
      .PCSrc_o(pcs_w[g]), .branch_target_o(bt_w[g]), .stall_o(stall_w[g]),
      .WB_RegWrite_o(rw_w[g]), .WB_MemtoReg_o(m2r_w[g]), .Read_data_o(rd_w[g]),
      .ALU_result_o(alu_w[g]), .MUX2_o(mux_w[g]), .misalign_o(mis_w[g])
    );
  end

  exp_t act;
  always_comb begin
    act       = '0;
    act.stall = stall_w[sel];
    act.pcs   = pcs_w[sel];
    act.bt    = bt_w[sel];
    act.rw    = rw_w[sel];
    act.m2r   = m2r_w[sel];
    act.rd    = rd_w[sel];
    act.alu   = alu_w[sel];
    act.mux   = mux_w[sel];
    act.mis   = mis_w[sel];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t a, input exp_t e);
    chk({tag, ".stall"}, 32'(a.stall), 32'(e.stall));
    chk({tag, ".PCSrc"}, 32'(a.pcs), 32'(e.pcs));
    chk({tag, ".target"}, a.bt, e.bt);
    chk({tag, ".RegWrite"}, 32'(a.rw), 32'(e.rw));
    chk({tag, ".MemtoReg"}, 32'(a.m2r), 32'(e.m2r));
    chk({tag, ".Read_data"}, a.rd, e.rd);
    chk({tag, ".ALU_result"}, a.alu, e.alu);
    chk({tag, ".MUX2"}, 32'(a.mux), 32'(e.mux));
    chk({tag, ".misalign"}, 32'(a.mis), 32'(e.mis));
  endtask

  // Scoreboard: each entry holds the combinational values seen during the cycle
  // and the MEM/WB contents expected after the edge that closes it.
  exp_t  q [$];
  string qn [$];
  logic  s_stall, s_pcs;
  logic [31:0] s_bt;
  exp_t  m_e, m_a;
  string m_n;

  always @(negedge clk) begin
    s_stall = act.stall;
    s_pcs   = act.pcs;
    s_bt    = act.bt;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      m_e = q.pop_front();
      m_n = qn.pop_front();
      m_a = act;
      m_a.stall = s_stall;
      m_a.pcs   = s_pcs;
      m_a.bt    = s_bt;
      chk_all(m_n, m_a, m_e);
    end
  end

  function automatic in_t mk(input logic rw, m2r, mr, mw, input logic [31:0] alu, wd,
                             input logic [4:0] mux);
    in_t i;
    i = '0;
    i.rw = rw; i.m2r = m2r; i.mr = mr; i.mw = mw;
    i.alu = alu; i.wd = wd; i.mux = mux;
    return i;
  endfunction

  function automatic exp_t ex(input logic st, rw, m2r, input logic [31:0] rd, alu,
                              input logic [4:0] mux, input logic mis);
    exp_t e;
    e = '0;
    e.stall = st; e.rw = rw; e.m2r = m2r; e.rd = rd;
    e.alu = alu; e.mux = mux; e.mis = mis;
    return e;
  endfunction

  function automatic exp_t bub(input logic st);
    return ex(st, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
  endfunction

  task automatic step(input string nm, input in_t i, input exp_t e);
    @(posedge clk);
    #2;
    din = i;
    q.push_back(e);
    qn.push_back(nm);
  endtask

  task automatic switch_to(input logic [1:0] k);
    @(posedge clk);
    #3;
    sel = k;
  endtask

  in_t  ti;
  exp_t te;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    #1 chk_all("reset_init", act, '0);
    @(negedge clk) rst = 1'b0;

    // Asynchronous reset clears nonzero MEM/WB contents mid-cycle.
    step("mis_load", mk(1, 1, 1, 0, 32'h99, 0, 5'd4), ex(0, 1, 1, 0, 32'h99, 5'd4, 1));
    @(posedge clk);
    #3 rst = 1'b1;
    #1 chk_all("reset_async", act, '0);
    din = '0;
    @(negedge clk) rst = 1'b0;

    // MEM_LAT=2: store then load, write+read treated as write, branch passthrough.
    ti = mk(0, 0, 0, 1, 32'h10, 32'hDEADBEEF, 5'd0);
    step("st10_c1", ti, bub(1));
    step("st10_c2", ti, ex(0, 0, 0, 0, 32'h10, 5'd0, 0));
    ti = mk(1, 1, 1, 0, 32'h10, 32'd0, 5'd5);
    step("ld10_c1", ti, bub(1));
    step("ld10_c2", ti, ex(0, 1, 1, 32'hDEADBEEF, 32'h10, 5'd5, 0));
    ti = mk(1, 0, 1, 1, 32'h14, 32'hCAFEF00D, 5'd6);
    step("rw14_c1", ti, bub(1));
    step("rw14_c2", ti, ex(0, 1, 0, 0, 32'h14, 5'd6, 0));
    ti = mk(1, 1, 1, 0, 32'h14, 32'd0, 5'd2);
    step("ld14_c1", ti, bub(1));
    step("ld14_c2", ti, ex(0, 1, 1, 32'hCAFEF00D, 32'h14, 5'd2, 0));
    step("nop_pass", mk(1, 0, 0, 0, 32'h77, 0, 5'd3), ex(0, 1, 0, 0, 32'h77, 5'd3, 0));

    ti = mk(0, 0, 0, 0, 0, 0, 0); ti.br = 1; ti.zero = 1; ti.add2 = 32'h40;
    te = bub(0); te.pcs = 1; te.bt = 32'h40;
    step("br_taken", ti, te);
    ti.zero = 0; te.pcs = 0;
    step("br_not", ti, te);
    ti = mk(0, 0, 0, 1, 32'h20, 32'h5, 0); ti.br = 1; ti.zero = 1; ti.add2 = 32'h80;
    te = bub(1); te.pcs = 1; te.bt = 32'h80;
    step("br_stall_c1", ti, te);
    te = ex(0, 0, 0, 0, 32'h20, 0, 0); te.pcs = 1; te.bt = 32'h80;
    step("br_stall_c2", ti, te);

    // Misaligned accesses and address wrap-around.
    ti = mk(0, 0, 0, 1, 32'h200, 32'h0BADF00D, 0);
    step("st200_c1", ti, bub(1));
    step("st200_c2", ti, ex(0, 0, 0, 0, 32'h200, 0, 0));
    step("st202_mis", mk(1, 0, 0, 1, 32'h202, 32'h12345678, 5'd7), ex(0, 1, 0, 0, 32'h202, 5'd7, 1));
    ti = mk(1, 1, 1, 0, 32'h201, 0, 5'd1);
    step("ld201_mis_a", ti, ex(0, 1, 1, 0, 32'h201, 5'd1, 1));
    step("ld201_mis_b", ti, ex(0, 1, 1, 0, 32'h201, 5'd1, 1));
    step("mis_clear", '0, bub(0));
    ti = mk(1, 1, 1, 0, 32'h0, 0, 5'd8);
    step("ld0_c1", ti, bub(1));
    step("ld0_unchanged", ti, ex(0, 1, 1, 32'h0BADF00D, 32'h0, 5'd8, 0));
    ti = mk(0, 0, 0, 1, 32'h200, 32'hA5A5A5A5, 0);
    step("st200b_c1", ti, bub(1));
    step("st200b_c2", ti, ex(0, 0, 0, 0, 32'h200, 0, 0));
    ti = mk(1, 1, 1, 0, 32'h0, 0, 5'd8);
    step("ld0w_c1", ti, bub(1));
    step("ld0_wrap", ti, ex(0, 1, 1, 32'hA5A5A5A5, 32'h0, 5'd8, 0));
    step("nop_end2", '0, bub(0));

    // MEM_LAT=1: back-to-back stores and loads, no stall.
    switch_to(2'd0);
    for (int k = 0; k < 3; k++) begin
      step("l1_store", mk(0, 0, 0, 1, 32'(4 * k), 32'h11111111 * (k + 1), 0),
           ex(0, 0, 0, 0, 32'(4 * k), 0, 0));
    end
    for (int k = 0; k < 3; k++) begin
      step("l1_load", mk(1, 1, 1, 0, 32'(4 * k), 0, 5'(k + 1)),
           ex(0, 1, 1, 32'h11111111 * (k + 1), 32'(4 * k), 5'(k + 1), 0));
    end
    step("nop_end1", '0, bub(0));

    // MEM_LAT=3: reset during BUSY discards the pending store.
    switch_to(2'd2);
    ti = mk(0, 0, 0, 1, 32'h10, 32'h11111111, 0);
    step("l3_st_c1", ti, bub(1));
    step("l3_st_c2", ti, bub(1));
    step("l3_st_c3", ti, ex(0, 0, 0, 0, 32'h10, 0, 0));
    step("l3_abort_c1", mk(0, 0, 0, 1, 32'h10, 32'hDEADBEEF, 0), bub(1));
    @(posedge clk);
    #3 rst = 1'b1;
    #1 chk_all("l3_in_reset", act, '0);
    @(posedge clk);
    #1 chk_all("l3_reset_held", act, '0);
    @(negedge clk);
    rst = 1'b0;
    din = '0;
    ti = mk(1, 1, 1, 0, 32'h10, 0, 5'd4);
    step("l3_ld_c1", ti, bub(1));
    step("l3_ld_c2", ti, bub(1));
    step("l3_ld_kept", ti, ex(0, 1, 1, 32'h11111111, 32'h10, 5'd4, 0));
    step("nop_end3", '0, bub(0));

    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending entries expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
